// File: rtl/servant_wb_mux_n.sv
// rtl/servant_wb_mux_n.sv - Wishbone 1:N decoder/mux between the SERV data bus and NS slaves (optional timeout: SERVANT_WB_MUX_TIMEOUT_EN)
module servant_wb_mux_n #(
    parameter int NS      = 4,
    parameter int SEL_W   = 2,
    parameter int SEL_LSB = 30,
    parameter int TO_W    = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [31:0]      i_wb_cpu_adr,
    input  logic [31:0]      i_wb_cpu_dat,
    input  logic [3:0]       i_wb_cpu_sel,
    input  logic             i_wb_cpu_we,
    input  logic             i_wb_cpu_cyc,
    output logic [31:0]      o_wb_cpu_rdt,
    output logic             o_wb_cpu_ack,
    output logic             o_wb_cpu_err,
    output logic [NS*32-1:0] o_wb_s_adr,
    output logic [NS*32-1:0] o_wb_s_dat,
    output logic [NS*4-1:0]  o_wb_s_sel,
    output logic [NS-1:0]    o_wb_s_we,
    output logic [NS-1:0]    o_wb_s_cyc,
    input  logic [NS*32-1:0] i_wb_s_rdt,
    input  logic [NS-1:0]    i_wb_s_ack
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] adr_idx;
    logic             adr_mapped;
    logic             sel_ack;
    logic [31:0]      sel_rdt;
    logic             to_hit;

    assign adr_idx    = i_wb_cpu_adr[SEL_LSB+SEL_W-1:SEL_LSB];
    assign adr_mapped = (int'(adr_idx) < NS);

    // Request fields are broadcast; only cyc qualifies which slave acts on them.
    assign o_wb_s_adr = {NS{i_wb_cpu_adr}};
    assign o_wb_s_dat = {NS{i_wb_cpu_dat}};
    assign o_wb_s_sel = {NS{i_wb_cpu_sel}};
    assign o_wb_s_we  = {NS{i_wb_cpu_we}};

    // Select the latched slave's ack and read data; all other slaves are ignored.
    always_comb begin
        sel_ack = 1'b0;
        sel_rdt = 32'h0;
        for (int i = 0; i < NS; i++) begin
            if (idx == i[SEL_W-1:0]) begin
                sel_ack = i_wb_s_ack[i];
                sel_rdt = i_wb_s_rdt[i*32 +: 32];
            end
        end
    end

    // One-hot slave cyc in BUSY only; reset kills it in the same cycle it is sampled.
    always_comb begin
        o_wb_s_cyc = '0;
        for (int i = 0; i < NS; i++) begin
            o_wb_s_cyc[i] = !i_rst && (state == S_BUSY) &&
                            (idx == i[SEL_W-1:0]) && i_wb_cpu_cyc;
        end
    end

`ifdef SERVANT_WB_MUX_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;
    logic [TO_W-1:0] to_nxt;

    assign to_nxt = to_cnt + {{(TO_W-1){1'b0}}, 1'b1};
    // Expire on the BUSY cycle whose increment would reach the all-ones count.
    assign to_hit = &to_nxt;

    // Count BUSY cycles without an ack; cleared everywhere else.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            to_cnt <= '0;
        end else if (state == S_BUSY && i_wb_cpu_cyc && !sel_ack) begin
            to_cnt <= to_nxt;
        end else begin
            to_cnt <= '0;
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    // Transaction FSM with registered ack/err/rdt towards the CPU.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= S_IDLE;
            idx          <= '0;
            o_wb_cpu_ack <= 1'b0;
            o_wb_cpu_err <= 1'b0;
            o_wb_cpu_rdt <= 32'h0;
        end else begin
            o_wb_cpu_ack <= 1'b0;
            o_wb_cpu_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_wb_cpu_cyc) begin
                        idx <= adr_idx;
                        if (adr_mapped) begin
                            state <= S_BUSY;
                        end else begin
                            state        <= S_DONE;
                            o_wb_cpu_ack <= 1'b1;
                            o_wb_cpu_err <= 1'b1;
                            o_wb_cpu_rdt <= 32'h0;
                        end
                    end
                end
                S_BUSY: begin
                    if (!i_wb_cpu_cyc) begin
                        state <= S_IDLE;
                    end else if (sel_ack) begin
                        state        <= S_DONE;
                        o_wb_cpu_ack <= 1'b1;
                        o_wb_cpu_rdt <= sel_rdt;
                    end else if (to_hit) begin
                        state        <= S_DONE;
                        o_wb_cpu_ack <= 1'b1;
                        o_wb_cpu_err <= 1'b1;
                        o_wb_cpu_rdt <= 32'h0;
                    end
                end
                // DONE absorbs the cycle in which the CPU still holds cyc after the ack.
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_servant_wb_mux_n.sv
// tb/tb_servant_wb_mux_n.sv - scoreboard bench for servant_wb_mux_n
module tb_servant_wb_mux_n;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  adr, dat;
    logic [3:0]   sel;
    logic         we, cyc;
    logic [31:0]  rdt;
    logic         ack, err;
    logic [127:0] s_adr, s_dat, s_rdt;
    logic [15:0]  s_sel;
    logic [3:0]   s_we, s_cyc, s_ack;

    logic [31:0]  adr3;
    logic         cyc3;
    logic [31:0]  rdt3;
    logic         ack3, err3;
    logic [95:0]  s_adr3, s_dat3, s_rdt3;
    logic [11:0]  s_sel3;
    logic [2:0]   s_we3, s_cyc3, s_ack3;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] rdt;
        logic        err;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    servant_wb_mux_n #(.NS(4)) u_dut (
        .i_clk(clk), .i_rst(rst),
        .i_wb_cpu_adr(adr), .i_wb_cpu_dat(dat), .i_wb_cpu_sel(sel),
        .i_wb_cpu_we(we), .i_wb_cpu_cyc(cyc),
        .o_wb_cpu_rdt(rdt), .o_wb_cpu_ack(ack), .o_wb_cpu_err(err),
        .o_wb_s_adr(s_adr), .o_wb_s_dat(s_dat), .o_wb_s_sel(s_sel),
        .o_wb_s_we(s_we), .o_wb_s_cyc(s_cyc),
        .i_wb_s_rdt(s_rdt), .i_wb_s_ack(s_ack)
    );

    servant_wb_mux_n #(.NS(3)) u_dut3 (
        .i_clk(clk), .i_rst(rst),
        .i_wb_cpu_adr(adr3), .i_wb_cpu_dat(dat), .i_wb_cpu_sel(sel),
        .i_wb_cpu_we(we), .i_wb_cpu_cyc(cyc3),
        .o_wb_cpu_rdt(rdt3), .o_wb_cpu_ack(ack3), .o_wb_cpu_err(err3),
        .o_wb_s_adr(s_adr3), .o_wb_s_dat(s_dat3), .o_wb_s_sel(s_sel3),
        .o_wb_s_we(s_we3), .o_wb_s_cyc(s_cyc3),
        .i_wb_s_rdt(s_rdt3), .i_wb_s_ack(s_ack3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard: every CPU ack must match the oldest pending expectation.
    always @(negedge clk) begin
        if (ack) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", 32'(ack), 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rdt", rdt, e.rdt);
                check("err", 32'(err), 32'(e.err));
            end
        end else if (err) begin
            check("err_without_ack", 32'(err), 32'h0);
        end
    end

    // dly < 0: slave never acks (timeout expected); otherwise slave acks at cycle dly+1.
    task automatic do_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic w, input int dly, input logic [31:0] srdt, input bit spur);
        logic [1:0] t2;
        int  tgt, cyc_n, exp_lat;
        bit  done, exp_err;
        t2      = a[31:30];
        tgt     = int'(t2);
        cyc_n   = 0;
        done    = 1'b0;
        exp_err = (dly < 0);
        exp_lat = exp_err ? 16 : dly + 2;
        sb.push_back('{exp_err ? 32'h0 : srdt, exp_err});
        @(negedge clk);
        adr = a; dat = d; sel = s; we = w; cyc = 1'b1; s_ack = '0;
        s_rdt[tgt*32 +: 32] = srdt;
        while (!done && cyc_n < 60) begin
            @(negedge clk);
            cyc_n++;
            s_ack = '0;
            if (ack) begin
                check("ack_latency", 32'(cyc_n), 32'(exp_lat));
                check("cyc_at_ack", 32'(s_cyc), 32'h0);
                cyc  = 1'b0;
                done = 1'b1;
            end else begin
                if (cyc_n == 1 || cyc_n == 15)
                    check("cyc_onehot", 32'(s_cyc), 32'(4'b0001 << tgt));
                if (w) begin
                    check("wr_dat", s_dat[tgt*32 +: 32], d);
                    check("wr_sel_we", 32'({s_we[tgt], s_sel[tgt*4 +: 4]}), 32'({1'b1, s}));
                end
                if (cyc_n - 1 == dly)
                    s_ack[tgt] = 1'b1;
                else if (spur)
                    s_ack[(tgt + 2) % 4] = 1'b1;
            end
        end
        if (!done) begin
            check("ack_timeout", 32'h0, 32'h1);
            cyc = 1'b0;
        end
        s_ack = '0;
        s_rdt[tgt*32 +: 32] = 32'hBAD0_0000 | 32'(tgt);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cyc = 1'b0; cyc3 = 1'b0;
        adr = '0; adr3 = '0; dat = '0; sel = '0; we = 1'b0;
        s_ack = '0; s_ack3 = '0;
        s_rdt  = {32'hBAD0_0003, 32'hBAD0_0002, 32'hBAD0_0001, 32'hBAD0_0000};
        s_rdt3 = {32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
        repeat (3) @(negedge clk);
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_rdt", rdt, 32'h0);
        check("rst_cyc", 32'(s_cyc), 32'h0);
        rst = 1'b0;

        // Read slave 1, ack one cycle after its cyc.
        do_txn(32'h4000_0010, 32'h0, 4'hF, 1'b0, 1, 32'hDEAD_BEEF, 1'b0);
        // Write slave 3 with a 5-cycle ack delay.
        do_txn(32'hC000_0000, 32'h1234_5678, 4'b0011, 1'b1, 5, 32'h5555_AAAA, 1'b0);

        // Unmapped access on the 3-slave instance.
        @(negedge clk);
        adr3 = 32'hC000_0000; cyc3 = 1'b1;
        @(negedge clk);
        check("unm_ack", 32'(ack3), 32'h1);
        check("unm_err", 32'(err3), 32'h1);
        check("unm_rdt", rdt3, 32'h0);
        check("unm_cyc", 32'(s_cyc3), 32'h0);
        cyc3 = 1'b0;
        @(negedge clk);
        check("unm_ack_pulse", 32'({ack3, err3}), 32'h0);
        @(negedge clk);
        check("unm_idle_cyc", 32'(s_cyc3), 32'h0);
        cyc3 = 1'b1; adr3 = 32'h8000_0000;
        @(negedge clk);
        check("ns3_mapped_cyc", 32'(s_cyc3), 32'h4);
        check("ns3_mapped_noack", 32'(ack3), 32'h0);
        cyc3 = 1'b0;
        @(negedge clk);

`ifdef SERVANT_WB_MUX_TIMEOUT_EN
        do_txn(32'h0000_0000, 32'h0, 4'hF, 1'b0, -1, 32'h7777_0000, 1'b0);
        do_txn(32'h0000_0004, 32'h0, 4'hF, 1'b0, 14, 32'h7777_0001, 1'b0);
`else
        do_txn(32'h0000_0000, 32'h0, 4'hF, 1'b0, 20, 32'h7777_0002, 1'b0);
`endif

        // Reset in the middle of a slave-2 access.
        @(negedge clk);
        adr = 32'h8000_0000; we = 1'b0; cyc = 1'b1;
        repeat (3) @(negedge clk);
        check("pre_rst_cyc", 32'(s_cyc), 32'h4);
        rst = 1'b1;
        #1;
        check("rst_cyc_same", 32'(s_cyc), 32'h0);
        @(negedge clk);
        check("post_rst_cyc", 32'(s_cyc), 32'h0);
        check("post_rst_ack", 32'(ack), 32'h0);
        rst = 1'b0; cyc = 1'b0;
        do_txn(32'h8000_0004, 32'h0, 4'hF, 1'b0, 2, 32'h0246_8ACE, 1'b0);

        // Slave 0 selected while slave 2 acks spuriously.
        do_txn(32'h0000_0100, 32'h0, 4'hF, 1'b0, 4, 32'hCAFE_0000, 1'b1);

        // Back-to-back random transactions.
        for (int i = 0; i < 10; i++) begin
            logic [1:0]  ri;
            logic [31:0] ra, rd;
            ri = 2'($urandom_range(0, 3));
            ra = {ri, 30'($urandom_range(0, 255) * 4)};
            rd = $urandom;
            do_txn(ra, rd, 4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 4), rd ^ 32'hA5A5_5A5A, 1'($urandom_range(0, 1)));
        end

        repeat (4) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
